// File: rtl/fetch_unit_if.sv
// fetch_unit_if: in-order instruction-memory request/response channel
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
    modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, buffering imem responses and driving the IF/ID register
module fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_stall_c,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    fetch_unit_if.master      imem,
    output logic [ADDR_W-1:0] IF_ID_nextPC,
    output logic [DATA_W-1:0] IF_ID_IR,
    output logic              IF_ID_valid,
    output logic              if_stall_c
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);
    logic [ADDR_W-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]     outstanding, drop_cnt, count;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [ADDR_W-1:0] buf_pc [BUF_DEPTH];
    logic [DATA_W-1:0] buf_ir [BUF_DEPTH];
    logic              req_fire, kept, load, pop, bypass, push;
    // outstanding + count is the credit: every accepted request has a guaranteed buffer slot
    assign imem.req_valid = reset_n && !br_taken && (outstanding + count) < DEPTH;
    assign imem.req_addr  = fetch_pc;
    always_comb begin
        req_fire   = imem.req_valid && imem.req_ready;
        kept       = imem.resp_valid && drop_cnt == '0 && !br_taken;
        load       = !id_stall_c && !br_taken;
        pop        = load && count != '0;
        bypass     = load && count == '0 && kept;
        push       = kept && !bypass;
        if_stall_c = load && count == '0 && !kept;
    end
    always_ff @(posedge clock) begin
        if (push) begin
            buf_pc[wr_ptr] <= resp_pc;
            buf_ir[wr_ptr] <= imem.resp_data;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc     <= RESET_PC;
            resp_pc      <= RESET_PC;
            outstanding  <= '0;
            drop_cnt     <= '0;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            IF_ID_nextPC <= '0;
            IF_ID_IR     <= '0;
            IF_ID_valid  <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem.resp_valid);
            if (br_taken) begin
                fetch_pc    <= br_target;
                resp_pc     <= br_target;
                drop_cnt    <= outstanding - CW'(imem.resp_valid);
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                IF_ID_IR    <= '0;
                IF_ID_valid <= 1'b0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
                if (kept) resp_pc <= resp_pc + ADDR_W'(4);
                if (imem.resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (load) begin
                    IF_ID_valid <= pop || bypass;
                    IF_ID_IR    <= pop ? buf_ir[rd_ptr] : bypass ? imem.resp_data : '0;
                    if (pop || bypass) IF_ID_nextPC <= (pop ? buf_pc[rd_ptr] : resp_pc) + ADDR_W'(4);
                end
            end
        end
    end
    assert property (@(posedge clock) disable iff (!reset_n) (push && count == DEPTH) |-> pop);
    assert property (@(posedge clock) disable iff (!reset_n) imem.resp_valid |-> outstanding != '0);
    assert property (@(posedge clock) disable iff (!reset_n) drop_cnt <= outstanding);
endmodule
